// File: rtl/mem_latency_model_if.sv
// Request/response bus between a CPU port and one memory region model.
// Master is the requester (CPU side); slave is the memory model.
interface mem_latency_model_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_latency_model.sv
// Word-addressed memory region model with valid/ready requests, fixed read/write
// latency, byte-enabled writes and address-error reporting.
module mem_latency_model #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 100,
  parameter logic [31:0] BASE         = 32'h10010000,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned WR_LAT       = 1,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input logic                clk,
  input logic                rst,
  mem_latency_model_if.slave bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e           state_q;
  logic [15:0]      cnt_q;
  logic             wen_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;

  logic [29:0]      off_w;
  logic             addr_err;
  logic [IDX_W-1:0] idx_now;
  logic             accept;
  logic [15:0]      lat_m1;

  // Addresses below BASE wrap to huge offsets and fail the range check.
  assign off_w    = 30'((bus.req_addr - BASE) >> 2);
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (off_w >= 30'(DEPTH));
  assign idx_now  = off_w[IDX_W-1:0];
  assign accept   = bus.req_valid && ready_q;
  assign lat_m1   = bus.req_wen ? 16'(WR_LAT - 1) : 16'(RD_LAT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            wen_q   <= bus.req_wen;
            err_q   <= addr_err;
            idx_q   <= idx_now;
            cnt_q   <= lat_m1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (lat_m1 == 16'd0) begin
              state_q <= StResp;
              valid_q <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q <= 16'd1) begin
            cnt_q   <= '0;
            state_q <= StResp;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Writes commit at the accept edge; erroring writes touch nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem[i] <= '0;
        end
      end
    end else if (accept && bus.req_wen && !addr_err) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (bus.req_be[b]) begin
          mem[idx_now][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_err   = valid_q && err_q;
  assign bus.resp_rdata = (valid_q && !err_q && !wen_q) ? mem[idx_q] : '0;
endmodule
